// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared load/store encodings and data-memory controller state type
package rv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } mem_state_t;

  // Read and write together is never a valid request, whatever funct3 says.
  function automatic logic req_illegal(input logic rd, input logic wr, input logic [2:0] f3);
    if (rd && wr) return 1'b1;
    if (wr) return !(f3 inside {F3_B, F3_H, F3_W});
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

  function automatic logic req_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - lane select plus sign/zero extension of a loaded word
module load_extend
  import rv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h000000, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0000, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - multi-cycle data-memory responder with byte-enable stores
// and extended loads; stalls the core while an access is in flight.
module data_mem_ctrl
  import rv_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        misalign,
  output logic        illegal
);

  localparam int IDX_W = $clog2(DEPTH);

  mem_state_t state, state_next;
  logic [3:0] cnt;

  logic [IDX_W-1:0] cap_idx;
  logic [1:0]       cap_lane;
  logic [31:0]      cap_wdata;
  logic [2:0]       cap_f3;
  logic             cap_write;

  logic [31:0] ram [DEPTH];

  logic        req;
  logic        req_bad;
  logic        req_mis;
  logic        req_ok;
  logic        access;
  logic [3:0]  byte_en;
  logic [31:0] wr_lanes;
  logic [31:0] ram_word;
  logic [31:0] load_result;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr[31:IDX_W+2];

  assign req     = mem_read | mem_write;
  assign req_bad = req && req_illegal(mem_read, mem_write, funct3);
  assign req_mis = req && !req_bad && req_misaligned(funct3, addr[1:0]);
  assign req_ok  = req && !req_bad && !req_mis;
  assign access  = (state == ST_WAIT) && (cnt == 4'd0);
  assign done    = (state == ST_DONE);

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_ok) begin
          stall      = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (cnt == 4'd0) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      rdata    <= 32'h0;
      misalign <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state    <= state_next;
      misalign <= (state == ST_IDLE) && req_mis;
      illegal  <= (state == ST_IDLE) && req_bad;
      if ((state == ST_IDLE) && req_ok) cnt <= 4'(LATENCY);
      else if ((state == ST_WAIT) && (cnt != 4'd0)) cnt <= cnt - 4'd1;
      if (access && !cap_write) rdata <= load_result;
    end
  end

  // Request fields are latched once so the core may change its buses during WAIT.
  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && req_ok) begin
      cap_idx   <= addr[IDX_W+1:2];
      cap_lane  <= addr[1:0];
      cap_wdata <= wdata;
      cap_f3    <= funct3;
      cap_write <= mem_write;
    end
  end

  always_comb begin
    case (cap_f3[1:0])
      2'b00: begin
        byte_en  = 4'b0001 << cap_lane;
        wr_lanes = {4{cap_wdata[7:0]}};
      end
      2'b01: begin
        byte_en  = cap_lane[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{cap_wdata[15:0]}};
      end
      default: begin
        byte_en  = 4'b1111;
        wr_lanes = cap_wdata;
      end
    endcase
  end

  // RAM is deliberately not reset; a reset mid-access drops the pending store.
  always_ff @(posedge clk) begin
    if (!rst && access && cap_write) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) ram[cap_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  assign ram_word = ram[cap_idx];

  load_extend u_load_extend (
    .word   (ram_word),
    .funct3 (cap_f3),
    .lane   (cap_lane),
    .result (load_result)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - table-driven and randomized checks of data_mem_ctrl
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  int          sel;

  logic        rd0, wr0, rd1, wr1;
  logic [31:0] rdata0, rdata1;
  logic        stall0, stall1, done0, done1, mis0, mis1, ill0, ill1;
  logic [31:0] o_rdata;
  logic        o_stall, o_done, o_mis, o_ill;

  always #5 clk = ~clk;

  assign rd0 = rd && (sel == 0);
  assign wr0 = wr && (sel == 0);
  assign rd1 = rd && (sel == 1);
  assign wr1 = wr && (sel == 1);

  assign o_rdata = (sel == 1) ? rdata1 : rdata0;
  assign o_stall = (sel == 1) ? stall1 : stall0;
  assign o_done  = (sel == 1) ? done1  : done0;
  assign o_mis   = (sel == 1) ? mis1   : mis0;
  assign o_ill   = (sel == 1) ? ill1   : ill0;

  data_mem_ctrl #(.DEPTH(1024), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0), .funct3(f3),
    .addr(addr), .wdata(wdata), .rdata(rdata0), .stall(stall0), .done(done0),
    .misalign(mis0), .illegal(ill0)
  );

  data_mem_ctrl #(.DEPTH(16), .LATENCY(0)) dut1 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1), .funct3(f3),
    .addr(addr), .wdata(wdata), .rdata(rdata1), .stall(stall1), .done(done1),
    .misalign(mis1), .illegal(ill1)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  mm [2][4096];
  logic [31:0] last_rd [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic int nbytes(input int s);
    return (s == 1) ? 64 : 4096;
  endfunction

  function automatic int lat_of(input int s);
    return (s == 1) ? 0 : 2;
  endfunction

  function automatic int size_of(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // 0 = access, 1 = misaligned, 2 = illegal
  function automatic int classify(input bit r, input bit w, input logic [2:0] f, input logic [31:0] a);
    if (r && w) return 2;
    if (w && f > 3'd2) return 2;
    if (r && !(f <= 3'd2 || f == 3'd4 || f == 3'd5)) return 2;
    if ((f == 3'd1 || f == 3'd5) && a[0]) return 1;
    if (f == 3'd2 && a[1:0] != 2'b00) return 1;
    return 0;
  endfunction

  function automatic void model_store(input int s, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int base;
    base = int'(a % 32'(nbytes(s)));
    for (int i = 0; i < size_of(f); i++) mm[s][base+i] = d[8*i +: 8];
  endfunction

  function automatic logic [31:0] model_load(input int s, input logic [2:0] f, input logic [31:0] a);
    int     base, n;
    longint v;
    base = int'(a % 32'(nbytes(s)));
    n    = size_of(f);
    v    = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(mm[s][base+i]) << (8*i));
    if (!f[2] && n < 4 && v >= (longint'(1) << (8*n-1))) v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  task automatic do_access(input int s, input bit w, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd, input string name);
    int stalls, done_at;
    logic [31:0] want;
    sel = s;
    @(negedge clk);
    rd = !w; wr = w; f3 = f; addr = a; wdata = d;
    #1;
    stalls  = o_stall ? 1 : 0;
    done_at = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (o_done) begin
        done_at = c;
        chk($sformatf("%s stall_at_done", name), 32'(o_stall), 32'd0);
        break;
      end
      if (o_stall) stalls++;
      addr = $urandom; wdata = $urandom; f3 = 3'($urandom_range(0, 7));
    end
    chk($sformatf("%s stall_cycles", name), 32'(stalls), 32'(lat_of(s) + 2));
    chk($sformatf("%s done_cycle", name), 32'(done_at), 32'(lat_of(s) + 2));
    if (w) begin
      model_store(s, f, a, d);
      want = last_rd[s];
    end else begin
      want = exp_rd;
    end
    chk($sformatf("%s rdata", name), o_rdata, want);
    last_rd[s] = want;
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk($sformatf("%s idle_after", name), {30'd0, o_stall, o_done}, 32'd0);
  endtask

  task automatic do_reject(input int s, input bit r, input bit w, input logic [2:0] f,
                           input logic [31:0] a, input int kind, input string name);
    sel = s;
    @(negedge clk);
    rd = r; wr = w; f3 = f; addr = a; wdata = $urandom;
    #1;
    chk($sformatf("%s stall_req", name), 32'(o_stall), 32'd0);
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk($sformatf("%s misalign", name), 32'(o_mis), 32'(kind == 1));
    chk($sformatf("%s illegal", name), 32'(o_ill), 32'(kind == 2));
    chk($sformatf("%s busy", name), {30'd0, o_stall, o_done}, 32'd0);
    chk($sformatf("%s rdata_hold", name), o_rdata, last_rd[s]);
    @(negedge clk);
    chk($sformatf("%s pulse_end", name), {30'd0, o_mis, o_ill}, 32'd0);
  endtask

  typedef struct {
    int          s;
    bit          r;
    bit          w;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] d;
    int          kind;
    logic [31:0] expv;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0; sel = 0;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;

    tbl.push_back('{0, 0, 1, 3'b010, 32'h20,        32'hAAAA5555, 0, 32'h0});
    tbl.push_back('{0, 0, 1, 3'b010, 32'h40,        32'h55555555, 0, 32'h0});
    tbl.push_back('{0, 0, 1, 3'b010, 32'h10,        32'hDEADBEEF, 0, 32'h0});
    tbl.push_back('{0, 1, 0, 3'b010, 32'h10,        32'h0,        0, 32'hDEADBEEF});
    tbl.push_back('{0, 0, 1, 3'b000, 32'h13,        32'h12345680, 0, 32'h0});
    tbl.push_back('{0, 1, 0, 3'b000, 32'h13,        32'h0,        0, 32'hFFFFFF80});
    tbl.push_back('{0, 1, 0, 3'b100, 32'h13,        32'h0,        0, 32'h00000080});
    tbl.push_back('{0, 1, 0, 3'b010, 32'h10,        32'h0,        0, 32'h80ADBEEF});
    tbl.push_back('{0, 1, 0, 3'b000, 32'h11,        32'h0,        0, 32'hFFFFFFBE});
    tbl.push_back('{0, 1, 0, 3'b101, 32'h12,        32'h0,        0, 32'h000080AD});
    tbl.push_back('{0, 1, 0, 3'b001, 32'h12,        32'h0,        0, 32'hFFFF80AD});
    tbl.push_back('{0, 0, 1, 3'b001, 32'h22,        32'hABCD1234, 0, 32'h0});
    tbl.push_back('{0, 1, 0, 3'b001, 32'h20,        32'h0,        0, 32'h00005555});
    tbl.push_back('{0, 1, 0, 3'b101, 32'h22,        32'h0,        0, 32'h00001234});
    tbl.push_back('{0, 1, 0, 3'b010, 32'h20,        32'h0,        0, 32'h12345555});
    tbl.push_back('{0, 1, 0, 3'b001, 32'h21,        32'h0,        1, 32'h0});
    tbl.push_back('{0, 0, 1, 3'b001, 32'h21,        32'h0,        1, 32'h0});
    tbl.push_back('{0, 0, 1, 3'b010, 32'h12,        32'h0,        1, 32'h0});
    tbl.push_back('{0, 1, 0, 3'b010, 32'h20,        32'h0,        0, 32'h12345555});
    tbl.push_back('{0, 1, 1, 3'b010, 32'h10,        32'h0,        2, 32'h0});
    tbl.push_back('{0, 1, 0, 3'b011, 32'h10,        32'h0,        2, 32'h0});
    tbl.push_back('{0, 0, 1, 3'b100, 32'h10,        32'h0,        2, 32'h0});
    tbl.push_back('{0, 1, 1, 3'b001, 32'h21,        32'h0,        2, 32'h0});
    tbl.push_back('{0, 0, 1, 3'b010, 32'h1000,      32'hCAFEF00D, 0, 32'h0});
    tbl.push_back('{0, 1, 0, 3'b010, 32'h0,         32'h0,        0, 32'hCAFEF00D});
    tbl.push_back('{0, 1, 0, 3'b010, 32'hFFFFF010,  32'h0,        0, 32'h80ADBEEF});
    tbl.push_back('{1, 0, 1, 3'b010, 32'h10,        32'hDEADBEEF, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 3'b010, 32'h10,        32'h0,        0, 32'hDEADBEEF});
    tbl.push_back('{1, 0, 1, 3'b010, 32'h44,        32'h01020304, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 3'b010, 32'h04,        32'h0,        0, 32'h01020304});
    tbl.push_back('{1, 1, 0, 3'b100, 32'h07,        32'h0,        0, 32'h00000001});
    tbl.push_back('{1, 1, 1, 3'b000, 32'h00,        32'h0,        2, 32'h0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset dut0 outs", {rdata0[31:4], stall0, done0, mis0, ill0} | {28'd0, rdata0[3:0]}, 32'd0);
    chk("reset dut1 outs", {rdata1[31:4], stall1, done1, mis1, ill1} | {28'd0, rdata1[3:0]}, 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      if (tbl[i].kind == 0)
        do_access(tbl[i].s, tbl[i].w, tbl[i].f, tbl[i].a, tbl[i].d, tbl[i].expv, $sformatf("vec%0d", i));
      else
        do_reject(tbl[i].s, tbl[i].r, tbl[i].w, tbl[i].f, tbl[i].a, tbl[i].kind, $sformatf("vec%0d", i));
    end

    // Reset in the first WAIT cycle of a store must drop the store.
    sel = 0;
    @(negedge clk);
    rd = 1'b0; wr = 1'b1; f3 = 3'b010; addr = 32'h40; wdata = 32'h11111111;
    @(posedge clk);
    #1;
    wr = 1'b0;
    @(negedge clk);
    chk("rstwait stall", 32'(stall0), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstwait outs", {27'd0, stall0, done0, mis0, ill0, stall1}, 32'd0);
    chk("rstwait rdata0", rdata0, 32'd0);
    chk("rstwait rdata1", rdata1, 32'd0);
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    begin
      int busy;
      busy = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (stall0 || done0) busy++;
      end
      chk("rstwait idle", 32'(busy), 32'd0);
    end
    do_access(0, 1'b0, 3'b010, 32'h40, 32'h0, 32'h55555555, "rstwait reload");

    for (int i = 0; i < 16; i++) begin
      do_access(0, 1'b1, 3'b010, 32'h100 + 32'(4*i), $urandom, 32'h0, $sformatf("init0_%0d", i));
      do_access(1, 1'b1, 3'b010, 32'(4*i), $urandom, 32'h0, $sformatf("init1_%0d", i));
    end

    for (int i = 0; i < 60; i++) begin
      int          s, x, kind;
      bit          r, w;
      logic [2:0]  f;
      logic [31:0] a, off;
      s   = $urandom_range(0, 1);
      x   = $urandom_range(0, 9);
      r   = (x < 5);
      w   = (x == 0) || (x >= 5);
      f   = 3'($urandom_range(0, 7));
      off = 32'($urandom_range(0, 63));
      a   = (s == 1) ? (($urandom & 32'hFFFFFFC0) | off) : (($urandom & 32'hFFFFF000) | 32'h100 | off);
      kind = classify(r, w, f, a);
      if (kind == 0)
        do_access(s, w, f, a, $urandom, w ? 32'h0 : model_load(s, f, a), $sformatf("rand%0d", i));
      else
        do_reject(s, r, w, f, a, kind, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Multi-cycle data-memory responder that services the memRead/memWrite requests issued by the CPU's control unit. It owns a word-organised RAM, performs byte/half/word stores with byte enables, and performs sign- or zero-extended loads. It stalls the core while an access is in flight. It sits between the datapath's ALU-result/rs2 buses and the writeback mux (memtoReg path).

Parameters:
DEPTH, 1024, number of 32-bit words in the RAM; must be a power of 2; the word index is addr[log2(DEPTH)+1:2].
LATENCY, 2, number of extra wait cycles per access; legal range 0..15.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
mem_read  in  1  load request from the control unit
mem_write  in  1  store request from the control unit
funct3  in  3  access size/sign field of the instruction
addr  in  32  byte address (ALU result)
wdata  in  32  store data (rs2)
rdata  out  32  extended load result, held until the next completed load
stall  out  1  freezes the PC and pipeline while high
done  out  1  one-cycle pulse when an access completes
misalign  out  1  one-cycle pulse for a misaligned request (no access performed)
illegal  out  1  one-cycle pulse for a bad funct3, or for read and write both high

Behaviour:
- Reset (synchronous, rst=1 at the edge): state=IDLE, counter=0; rdata=0, stall=0, done=0, misalign=0, illegal=0. Reset does not clear RAM contents. Reset during WAIT or DONE abandons the access, and an abandoned store is not written.
- FSM states: IDLE, WAIT, DONE.
- IDLE, with no request: stays in IDLE; all outputs low except rdata, which holds.
- IDLE, with a request (mem_read or mem_write):
  - Legal and aligned: capture addr, wdata, funct3 and the read/write direction; load counter=LATENCY; go to WAIT. stall is combinationally high in this same cycle.
  - Misaligned (half access with addr[0]=1, or word access with addr[1:0]!=0): misalign=1 for the next cycle; stay in IDLE; stall stays low; no RAM access.
  - Illegal, meaning any of the following: a store with funct3 not in {000,001,010}; a load with funct3 not in {000,001,010,100,101}; or mem_read=mem_write=1. Response: illegal=1 for the next cycle; stay in IDLE; no access; stall stays low. Illegal takes priority over misalign.
- WAIT: stall=1. While counter>0, decrement it. When counter==0:
  - Perform the access at this edge.
  - Store: write only the byte lanes selected by funct3 and addr[1:0]. SB writes wdata[7:0] into lane addr[1:0]; SH writes wdata[15:0] into lanes {addr[1],0},{addr[1],1}; SW writes all four lanes.
  - Load: read the word and extract the selected lane(s). LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through. Register the result into rdata.
  - Go to DONE.
- DONE: stall=0, done=1; the core advances at this edge. Request inputs are ignored in this cycle because they still belong to the completing instruction. Go to IDLE.
- Timing: a request first seen in IDLE at cycle t keeps stall high for cycles t..t+LATENCY+1, i.e. LATENCY+2 cycles. done and the new rdata appear at cycle t+LATENCY+2. With LATENCY=0, stall lasts 2 cycles.
- Address wrap: address bits above log2(DEPTH)+1 are ignored, so the index wraps modulo DEPTH.
- Inputs may change while in WAIT; only the captured copies are used.
- Byte lanes are little-endian: lane 0 is bits [7:0].

Decomposition:
- Shared package (rv_pkg): funct3 encodings F3_B/F3_H/F3_W/F3_BU/F3_HU, and the FSM state enum.
- Natural sub-module: load_extend (combinational lane-select plus sign/zero extension). The controller instantiates it; it is also reusable for a future load/store unit.
- The RAM stays inline as a byte-enable register array.

Test Plan:
1. SW 0xDEADBEEF @0x10, then LW @0x10 with LATENCY=2: stall is high for 4 cycles per access, done pulses on the 5th, rdata=0xDEADBEEF.
2. SB 0x80 @0x13, then LB @0x13 and LBU @0x13: rdata=0xFFFFFF80 and 0x00000080 respectively; LW @0x10 gives 0x80ADBEEF.
3. SH 0x1234 @0x22, then LH/LW @0x20: the word holds 0x1234xxxx with the lower half unchanged. LH @0x21 gives misalign=1 next cycle, stall never high, RAM unchanged.
4. mem_read=mem_write=1, or load funct3=011: illegal pulses for 1 cycle, no stall; rdata keeps its previous value.
5. Assert rst in the WAIT cycle of SW 0x11111111 @0x40: outputs return to 0, state IDLE, and a following LW @0x40 returns the prior contents (not 0x11111111).
6. DEPTH=1024: SW 0xCAFEF00D @0x1000 then LW @0x0000 returns 0xCAFEF00D (wrap). Re-run test 1 with LATENCY=0: stall lasts exactly 2 cycles.
